// File: rtl/i2c_slave_regfile.sv
// I2C responder with a 16 x 8 register file behind a 4-bit auto-incrementing pointer.
// SCL/SDA are synchronized and glitch-filtered; all bus events derive from the filtered levels.
module i2c_slave_regfile #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h55,
  parameter int unsigned GLITCH_CYC = 2
) (
  input  logic       CLOCK_IN,
  input  logic       RESET_N,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       WR_STB,
  output logic [3:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  input  logic [3:0] REG_SEL,
  output logic [7:0] REG_Q,
  output logic       BUSY
);

  localparam int unsigned CntW = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC + 1) : 1;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } state_e;

  logic [1:0]      scl_sync_q, sda_sync_q;
  logic            scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic [CntW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        ack_drv_q, ack_drv_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        wr_stb_q, wr_stb_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  regs_q [16];
  logic        reg_we;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  // A level change is accepted only after GLITCH_CYC consecutive differing samples.
  function automatic logic [CntW:0] filt_step(input logic sample, input logic level,
                                              input logic [CntW-1:0] cnt);
    if (sample == level) begin
      return {level, {CntW{1'b0}}};
    end else if (32'(cnt) + 32'd1 >= GLITCH_CYC) begin
      return {sample, {CntW{1'b0}}};
    end else begin
      return {level, cnt + 1'b1};
    end
  endfunction

  assign {scl_f_d, scl_cnt_d} = filt_step(scl_sync_q[1], scl_f_q, scl_cnt_q);
  assign {sda_f_d, sda_cnt_d} = filt_step(sda_sync_q[1], sda_f_q, sda_cnt_q);

  assign scl_rise  = scl_f_d & ~scl_f_q;
  assign scl_fall  = ~scl_f_d & scl_f_q;
  assign start_det = sda_f_q & ~sda_f_d & scl_f_q & scl_f_d;
  assign stop_det  = ~sda_f_q & sda_f_d & scl_f_q & scl_f_d;
  assign rx_byte   = {shift_q[6:0], sda_f_d};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    ack_drv_d = ack_drv_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    reg_we    = 1'b0;

    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      ack_drv_d = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      ack_drv_d = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == StAddr) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = StAddrAck;
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = StIgnore;
                  busy_d  = 1'b0;
                end
              end else if (state_q == StPtr) begin
                ptr_d   = rx_byte[3:0];
                state_d = StPtrAck;
              end else begin
                reg_we    = 1'b1;
                wr_stb_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = rx_byte;
                ptr_d     = ptr_q + 4'd1;
                state_d   = StWdataAck;
              end
            end
          end
        end
        // First falling edge starts the ACK drive, the second ends the ACK slot.
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              ack_drv_d = 1'b1;
              sda_oe_d  = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == StAddrAck && rw_q) begin
                state_d  = StRdata;
                shift_d  = regs_q[ptr_q];
                sda_oe_d = ~regs_q[ptr_q][7];
              end else if (state_q == StAddrAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StRdata: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = StRdataAck;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
            end
          end
        end
        // Any falling edge seen here follows the master's ACK bit, so it starts the next byte.
        StRdataAck: begin
          if (scl_rise) begin
            ptr_d = ptr_q + 4'd1;
            if (sda_f_d) begin
              state_d = StIgnore;
            end
          end else if (scl_fall) begin
            state_d   = StRdata;
            bit_cnt_d = '0;
            shift_d   = regs_q[ptr_q];
            sda_oe_d  = ~regs_q[ptr_q][7];
          end
        end
        StIgnore: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = StIdle;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      ack_drv_q  <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], SCL};
      sda_sync_q <= {sda_sync_q[0], SDA};
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      ack_drv_q  <= ack_drv_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (reg_we) begin
      regs_q[ptr_q] <= rx_byte;
    end
  end

  assign SDA     = sda_oe_q ? 1'b0 : 1'bz;
  assign WR_STB  = wr_stb_q;
  assign WR_ADDR = wr_addr_q;
  assign WR_DATA = wr_data_q;
  assign REG_Q   = regs_q[REG_SEL];
  assign BUSY    = busy_q;

endmodule
